i2cmb_byte_sequencer: RTL

- Parametrised byte-level command sequencer for the next-generation I2C multi-bus master.
- Accepts queued byte commands (start, stop, write, read-ack, read-nak, set-bus, wait) from the Wishbone register front end.
- Expands each command into handshaked bit operations for a shared bit-level engine, and returns one response per command.
- Adds over the previous generation: a configurable command FIFO, up to NUM_BUSES buses with capture/busy tracking, arbitration-loss queue flush, and tick-based wait.

---
 rtl/i2cmb_byte_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2cmb_byte_sequencer.sv
// Byte-level command sequencer for the I2C multi-bus master.
// Commands are queued in a small FIFO, then expanded one at a time into
// handshaked bit operations for the shared bit engine. Each executed
// command produces exactly one response pulse.
module i2cmb_byte_sequencer #(
    parameter int NUM_BUSES  = 16,
    parameter int BUS_ID_W   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [2:0]           cmd_code_i,
    input  logic [7:0]           cmd_data_i,
    output logic                 rsp_valid_o,
    output logic [1:0]           rsp_code_o,
    output logic [7:0]           rsp_data_o,
    output logic                 bit_req_o,
    output logic [1:0]           bit_op_o,
    output logic                 bit_dout_o,
    input  logic                 bit_done_i,
    input  logic                 bit_din_i,
    input  logic                 bit_arb_lost_i,
    input  logic [NUM_BUSES-1:0] bus_busy_i,
    input  logic                 tick_i,
    output logic [BUS_ID_W-1:0]  cur_bus_o,
    output logic                 captured_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] CMD_WAIT     = 3'b000;
    localparam logic [2:0] CMD_WRITE    = 3'b001;
    localparam logic [2:0] CMD_READ_ACK = 3'b010;
    localparam logic [2:0] CMD_READ_NAK = 3'b011;
    localparam logic [2:0] CMD_START    = 3'b100;
    localparam logic [2:0] CMD_STOP     = 3'b101;
    localparam logic [2:0] CMD_SET_BUS  = 3'b110;

    localparam logic [1:0] RSP_DONE = 2'b00;
    localparam logic [1:0] RSP_NAK  = 2'b01;
    localparam logic [1:0] RSP_ARB  = 2'b10;
    localparam logic [1:0] RSP_ERR  = 2'b11;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_START, S_WR_BITS, S_WR_ACK,
        S_RD_BITS, S_RD_ACK, S_STOP, S_WAIT, S_RESP
    } state_t;

    // ---------------- command FIFO ----------------
    logic [10:0]      mem [FIFO_DEPTH];
    logic [10:0]      head_reg;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             ready_reg;
    logic             push, pop, flush;

    state_t           state_reg, state_next;
    logic             arb_event;

    assign push        = cmd_valid_i && ready_reg;
    assign pop         = (state_reg == S_FETCH);
    assign flush       = arb_event;
    assign cmd_ready_o = ready_reg;

    // Storage array with a registered read of the head entry; the head is
    // re-read every cycle so it is valid by the time FETCH looks at it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_reg] <= {cmd_code_i, cmd_data_i};
        end
        head_reg <= mem[rd_ptr_reg];
    end

    // Occupancy after this edge; an arbitration flush also drops a concurrent push.
    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    // Pointer/count registers; ready is held low during reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ready_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            ready_reg <= (count_next != FULL_CNT);
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    // ---------------- selected bus busy ----------------
    logic [NUM_BUSES-1:0] busy_hit;
    logic                 busy_sel;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BUSES; gi++) begin : g_busy
            assign busy_hit[gi] = bus_busy_i[gi] && (cur_bus_o == BUS_ID_W'(gi));
        end
    endgenerate
    assign busy_sel = |busy_hit;

    // ---------------- sequencer ----------------
    logic [2:0]          cmd_code_reg, cmd_code_next;
    logic [7:0]          cmd_data_reg, cmd_data_next;
    logic [2:0]          bit_idx_reg, bit_idx_next;
    logic [7:0]          shift_reg, shift_next;
    logic [7:0]          wait_cnt_reg, wait_cnt_next;
    logic                gap_reg, gap_next;
    logic                issued_reg, issued_next;
    logic [1:0]          rsp_code_reg, rsp_code_next;
    logic [7:0]          rsp_data_reg, rsp_data_next;
    logic                captured_reg, captured_next;
    logic [BUS_ID_W-1:0] cur_bus_reg, cur_bus_next;
    logic                req;
    logic [1:0]          op;
    logic                dout;
    logic                done_ok;

    // Bit request presentation: one quiet cycle follows every completed op.
    always_comb begin
        req  = 1'b0;
        op   = OP_START;
        dout = 1'b0;
        case (state_reg)
            S_START: begin
                req = !gap_reg && (captured_reg || !busy_sel || issued_reg);
                op  = OP_START;
            end
            S_WR_BITS: begin
                req  = !gap_reg;
                op   = OP_WRITE;
                dout = cmd_data_reg[3'd7 - bit_idx_reg];
            end
            S_WR_ACK: begin
                req = !gap_reg;
                op  = OP_READ;
            end
            S_RD_BITS: begin
                req = !gap_reg;
                op  = OP_READ;
            end
            S_RD_ACK: begin
                req  = !gap_reg;
                op   = OP_WRITE;
                dout = (cmd_code_reg == CMD_READ_NAK);
            end
            S_STOP: begin
                req = !gap_reg;
                op  = OP_STOP;
            end
            default: ;
        endcase
    end

    assign done_ok   = req && bit_done_i && !bit_arb_lost_i;
    assign arb_event = req && bit_done_i && bit_arb_lost_i;

    // Next-state and datapath decisions for the current command.
    always_comb begin
        state_next    = state_reg;
        cmd_code_next = cmd_code_reg;
        cmd_data_next = cmd_data_reg;
        bit_idx_next  = bit_idx_reg;
        shift_next    = shift_reg;
        wait_cnt_next = wait_cnt_reg;
        gap_next      = 1'b0;
        issued_next   = issued_reg;
        rsp_code_next = rsp_code_reg;
        rsp_data_next = rsp_data_reg;
        captured_next = captured_reg;
        cur_bus_next  = cur_bus_reg;

        case (state_reg)
            S_IDLE: begin
                if (count_reg != '0) state_next = S_FETCH;
            end
            S_FETCH: begin
                cmd_code_next = head_reg[10:8];
                cmd_data_next = head_reg[7:0];
                bit_idx_next  = '0;
                shift_next    = '0;
                wait_cnt_next = '0;
                issued_next   = 1'b0;
                rsp_code_next = RSP_DONE;
                rsp_data_next = '0;
                case (head_reg[10:8])
                    CMD_WAIT:  state_next = (head_reg[7:0] == 8'd0) ? S_RESP : S_WAIT;
                    CMD_START: state_next = S_START;
                    CMD_WRITE: begin
                        state_next = captured_reg ? S_WR_BITS : S_RESP;
                        if (!captured_reg) rsp_code_next = RSP_ERR;
                    end
                    CMD_READ_ACK, CMD_READ_NAK: begin
                        state_next = captured_reg ? S_RD_BITS : S_RESP;
                        if (!captured_reg) rsp_code_next = RSP_ERR;
                    end
                    CMD_STOP: begin
                        state_next = captured_reg ? S_STOP : S_RESP;
                        if (!captured_reg) rsp_code_next = RSP_ERR;
                    end
                    CMD_SET_BUS: begin
                        state_next = S_RESP;
                        if (captured_reg || ({24'd0, head_reg[7:0]} >= 32'(NUM_BUSES))) begin
                            rsp_code_next = RSP_ERR;
                        end else begin
                            cur_bus_next = head_reg[BUS_ID_W-1:0];
                        end
                    end
                    default: begin
                        state_next    = S_RESP;
                        rsp_code_next = RSP_ERR;
                    end
                endcase
            end
            S_START: begin
                issued_next = req;
                if (done_ok) begin
                    captured_next = 1'b1;
                    state_next    = S_RESP;
                end
            end
            S_WR_BITS: begin
                if (done_ok) begin
                    gap_next     = 1'b1;
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) state_next = S_WR_ACK;
                end
            end
            S_WR_ACK: begin
                if (done_ok) begin
                    rsp_code_next = bit_din_i ? RSP_NAK : RSP_DONE;
                    state_next    = S_RESP;
                end
            end
            S_RD_BITS: begin
                if (done_ok) begin
                    gap_next     = 1'b1;
                    shift_next   = {shift_reg[6:0], bit_din_i};
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) state_next = S_RD_ACK;
                end
            end
            S_RD_ACK: begin
                if (done_ok) begin
                    rsp_data_next = shift_reg;
                    state_next    = S_RESP;
                end
            end
            S_STOP: begin
                if (done_ok) begin
                    captured_next = 1'b0;
                    state_next    = S_RESP;
                end
            end
            S_WAIT: begin
                if (tick_i) begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                    if (wait_cnt_reg + 8'd1 == cmd_data_reg) state_next = S_RESP;
                end
            end
            S_RESP: begin
                state_next = (count_reg != '0) ? S_FETCH : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        if (arb_event) begin
            captured_next = 1'b0;
            rsp_code_next = RSP_ARB;
            rsp_data_next = '0;
            gap_next      = 1'b0;
            state_next    = S_RESP;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg    <= S_IDLE;
            cmd_code_reg <= '0;
            cmd_data_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            wait_cnt_reg <= '0;
            gap_reg      <= 1'b0;
            issued_reg   <= 1'b0;
            rsp_code_reg <= '0;
            rsp_data_reg <= '0;
            captured_reg <= 1'b0;
            cur_bus_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            cmd_code_reg <= cmd_code_next;
            cmd_data_reg <= cmd_data_next;
            bit_idx_reg  <= bit_idx_next;
            shift_reg    <= shift_next;
            wait_cnt_reg <= wait_cnt_next;
            gap_reg      <= gap_next;
            issued_reg   <= issued_next;
            rsp_code_reg <= rsp_code_next;
            rsp_data_reg <= rsp_data_next;
            captured_reg <= captured_next;
            cur_bus_reg  <= cur_bus_next;
        end
    end

    assign bit_req_o   = req;
    assign bit_op_o    = op;
    assign bit_dout_o  = dout;
    assign rsp_valid_o = (state_reg == S_RESP);
    assign rsp_code_o  = rsp_valid_o ? rsp_code_reg : 2'b00;
    assign rsp_data_o  = rsp_valid_o ? rsp_data_reg : 8'h00;
    assign cur_bus_o   = cur_bus_reg;
    assign captured_o  = captured_reg;

endmodule
